// File: rtl/gate_tt_sequencer.sv
// rtl/gate_tt_sequencer.sv - walks a 2-input gate through 00,01,10,11 and checks its truth table
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] expected_tt,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] captured_tt,
  output logic [3:0] mismatch
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [3:0] exp_q;
  logic [3:0] tt_next;

  // Table including the bit being sampled this cycle, so DONE can judge the final vector.
  always_comb begin
    tt_next      = captured_tt;
    tt_next[idx] = f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= 8'd0;
      exp_q       <= 4'd0;
      a           <= 1'b0;
      b           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      captured_tt <= 4'd0;
      mismatch    <= 4'd0;
    end else if (abort) begin
      // Partial captured_tt is deliberately kept for inspection.
      state    <= IDLE;
      idx      <= 2'd0;
      cnt      <= 8'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          a    <= 1'b0;
          b    <= 1'b0;
          done <= 1'b0;
          if (start) begin
            exp_q       <= expected_tt;
            captured_tt <= 4'd0;
            mismatch    <= 4'd0;
            pass        <= 1'b0;
            idx         <= 2'd0;
            cnt         <= SETTLE_LOAD;
            busy        <= 1'b1;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SAMPLE: begin
          captured_tt <= tt_next;
          if (idx == 2'd3) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (tt_next == exp_q);
            mismatch <= tt_next ^ exp_q;
            a        <= 1'b0;
            b        <= 1'b0;
          end else begin
            idx    <= idx + 2'd1;
            {a, b} <= idx + 2'd1;
            cnt    <= SETTLE_LOAD;
            state  <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          idx   <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
